// File: rtl/quad_pkg.sv
// Shared types and defaults for the quadrature step decoder.
// Each decoder state carries the {A,B} level it expects to see on the debounced inputs.
package quad_pkg;

    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

    typedef enum logic [2:0] {
        StIdle,
        StCw1,
        StCw2,
        StCw3,
        StCcw1,
        StCcw2,
        StCcw3,
        StResync
    } quad_state_e;

    // Level of {A,B} that holds while the decoder sits in a given state.
    function automatic logic [1:0] state_code(input quad_state_e s);
        logic [1:0] code;
        case (s)
            StIdle:          code = 2'b11;
            StCw1, StCcw3:   code = 2'b01;
            StCw2, StCcw2:   code = 2'b00;
            StCw3, StCcw1:   code = 2'b10;
            default:         code = 2'b11;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Synchronizer chain followed by a stability counter for one raw encoder channel.
// The stable output only follows the synchronized input after DEBOUNCE_CYCLES steady cycles.
module debounce_bit
    import quad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_stable
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CntW-1:0]        r_cnt;
    logic                   r_stable;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync   <= '1;
            r_cnt    <= '0;
            r_stable <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            if (w_synced == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CntLast) begin
                r_stable <= w_synced;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CntW'(1);
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature encoder decoder: debounced A/B feed a detent-tracking FSM that emits
// one-cycle step_up / step_down pulses per full detent and err on illegal jumps.
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_in,
    input  logic       b_in,
    output logic       step_up,
    output logic       step_down,
    output logic       err,
    output logic [1:0] ab_stable
);

    logic        w_a_stable;
    logic        w_b_stable;
    logic [1:0]  w_ab;
    logic [1:0]  w_diff;

    quad_state_e r_state;
    logic        r_step_up;
    logic        r_step_down;
    logic        r_err;

    debounce_bit #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_a (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_raw    (a_in),
        .o_stable (w_a_stable)
    );

    debounce_bit #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_b (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_raw    (b_in),
        .o_stable (w_b_stable)
    );

    assign w_ab = {w_a_stable, w_b_stable};

    // Every tracking state holds a fixed level, so the XOR gives the bits that just moved.
    always_comb begin
        w_diff = w_ab ^ state_code(r_state);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_step_up   <= 1'b0;
            r_step_down <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_step_up   <= 1'b0;
            r_step_down <= 1'b0;
            r_err       <= 1'b0;
            if (r_state == StResync) begin
                if (w_ab == 2'b11) begin
                    r_state <= StIdle;
                end
            end else if (w_diff == 2'b11) begin
                r_err   <= 1'b1;
                r_state <= (w_ab == 2'b11) ? StIdle : StResync;
            end else if (w_diff != 2'b00) begin
                // One bit moved: either the next forward level or a step back.
                case (r_state)
                    StIdle: r_state <= (w_ab == 2'b01) ? StCw1 : StCcw1;
                    StCw1:  r_state <= (w_ab == 2'b00) ? StCw2 : StIdle;
                    StCw2:  r_state <= (w_ab == 2'b10) ? StCw3 : StCw1;
                    StCw3: begin
                        if (w_ab == 2'b11) begin
                            r_state   <= StIdle;
                            r_step_up <= 1'b1;
                        end else begin
                            r_state <= StCw2;
                        end
                    end
                    StCcw1: r_state <= (w_ab == 2'b00) ? StCcw2 : StIdle;
                    StCcw2: r_state <= (w_ab == 2'b01) ? StCcw3 : StCcw1;
                    StCcw3: begin
                        if (w_ab == 2'b11) begin
                            r_state     <= StIdle;
                            r_step_down <= 1'b1;
                        end else begin
                            r_state <= StCcw2;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign step_up   = r_step_up;
    assign step_down = r_step_down;
    assign err       = r_err;
    assign ab_stable = w_ab;

endmodule

// File: doc/quad_step_decoder.md
QUAD_STEP_DECODER -- requirements
Module: quad_step_decoder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops per input (minimum 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, the number of consecutive stable cycles required before a debounced value changes (minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port a_in, input, 1 bit: raw encoder channel A, asynchronous to clk.
REQ-006 SHALL have port b_in, input, 1 bit: raw encoder channel B, asynchronous to clk.
REQ-007 SHALL have port step_up, output, 1 bit: one-cycle pulse per completed clockwise detent.
REQ-008 SHALL have port step_down, output, 1 bit: one-cycle pulse per completed counter-clockwise detent.
REQ-009 SHALL have port err, output, 1 bit: one-cycle pulse on an illegal quadrature transition.
REQ-010 SHALL have port ab_stable, output, 2 bits: registered debounced {A,B}.

Function
REQ-011 SHALL pass each input through SYNC_STAGES flops before any other logic uses it.
REQ-012 Per channel, a counter SHALL reset to 0 whenever the synchronized value equals the stable value, and otherwise increment.
REQ-013 The stable bit SHALL take the synchronized value, and its counter SHALL clear, on the edge where the counter equals DEBOUNCE_CYCLES-1; one-cycle glitches shorter than DEBOUNCE_CYCLES SHALL never reach the stable bit.
REQ-014 The FSM SHALL have states IDLE(11), CW1(01), CW2(00), CW3(10), CCW1(10), CCW2(00), CCW3(01) and RESYNC; detent rest level is {A,B}=11.
REQ-015 Forward transitions SHALL be IDLE->CW1->CW2->CW3->IDLE and IDLE->CCW1->CCW2->CCW3->IDLE, each taken when ab_stable equals the target state's code.
REQ-016 A single-bit reversal SHALL move back exactly one state along the same path, with no pulse emitted.
REQ-017 CW3->IDLE SHALL assert step_up for the next cycle; CCW3->IDLE SHALL assert step_down for the next cycle.
REQ-018 A two-bit change of ab_stable in one cycle SHALL assert err for the next cycle and go to IDLE if the new value is 11, else to RESYNC.
REQ-019 RESYNC SHALL emit nothing and exit to IDLE only when ab_stable equals 11.
REQ-020 step_up and step_down SHALL never be asserted in the same cycle.
REQ-021 Latency from an input change to the step pulse SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 rising edges.

Reset
REQ-022 While rst is high at an edge: synchronizer flops and ab_stable SHALL load 11, counters 0, FSM IDLE, and step_up, step_down and err 0.
REQ-023 Reset asserted mid-rotation SHALL discard the partial detent with no pulse, both during and after reset.

Structure
REQ-024 The state enumeration and the default SYNC_STAGES and DEBOUNCE_CYCLES constants SHALL reside in the shared package quad_pkg.
REQ-025 Synchronizer plus debounce SHALL be a sub-module debounce_bit, instantiated once per channel; the FSM and pulse outputs SHALL reside in quad_step_decoder.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-026 Reset, then hold {A,B}=11 -> ab_stable=11; step_up, step_down and err stay 0.
REQ-027 Apply 11->01->00->10->11, each held 10 cycles -> exactly one step_up, 7 edges after the final change; no step_down.
REQ-028 Apply 11->10->00->01->11 -> exactly one step_down; then 11->01->11 (reversal) -> no pulse.
REQ-029 Add 2-cycle glitches on A during an idle hold -> ab_stable unchanged; no pulse and no err.
REQ-030 Apply 11->00 directly -> err pulse and FSM in RESYNC; then 00->10->11 -> no step; FSM IDLE.
REQ-031 Assert rst while in CW2, release, then drive 10->11 -> no step_up; FSM IDLE after release.
